// File: rtl/pulse_frame_receiver_pkg.sv
// Shared types and default frame constants for the pulse frame receiver.
// State encodings are fixed; the unused code 2'd3 is treated as illegal.
package pulse_frame_receiver_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StStop  = 2'd2
  } state_e;

  localparam int unsigned DefDataW   = 10;
  localparam logic [9:0]  DefPattern = 10'h14A;
  localparam int unsigned DefCntW    = 8;

  // Frame level of the start and stop bits on the serial line.
  localparam logic StartLevel = 1'b1;
  localparam logic StopLevel  = 1'b0;

endpackage

// File: rtl/serial_shift_reg.sv
// Indexed-load register: one bit is written at a time at a given position.
// A clear forces the whole word to zero and takes priority over a load.
module serial_shift_reg #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic              i_bit,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_clear) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q[i_idx] <= i_bit;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pulse_frame_receiver.sv
// Serial pulse-frame receiver: frames start/data/stop bits, deserializes the
// data LSB first, and counts good frames that equal PATTERN (saturating).
module pulse_frame_receiver
  import pulse_frame_receiver_pkg::*;
#(
  parameter int unsigned        DATA_W  = DefDataW,
  parameter logic [DATA_W-1:0]  PATTERN = DATA_W'(DefPattern),
  parameter int unsigned        CNT_W   = DefCntW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              signal,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic              frame_error,
  output logic              busy
);

  localparam int unsigned          BitCntW = $clog2(DATA_W);
  localparam logic [BitCntW-1:0]   LastIdx = BitCntW'(DATA_W - 1);

  state_e               r_state, w_state_next;
  logic [BitCntW-1:0]   r_bit_cnt, w_bit_cnt_next;

  logic [DATA_W-1:0]    r_data_out, w_data_out_next;
  logic                 r_data_valid, w_data_valid_next;
  logic                 r_match, w_match_next;
  logic [CNT_W-1:0]     r_match_count, w_match_count_next;
  logic                 r_frame_error, w_frame_error_next;
  logic                 r_busy, w_busy_next;

  logic                 w_sh_clear;
  logic                 w_sh_load;
  logic [DATA_W-1:0]    w_shreg;
  logic                 w_shreg_match;

  serial_shift_reg #(
    .DATA_W (DATA_W),
    .IDX_W  (BitCntW)
  ) u_shreg (
    .clock   (clock),
    .reset   (reset),
    .i_clear (w_sh_clear),
    .i_load  (w_sh_load),
    .i_idx   (r_bit_cnt),
    .i_bit   (signal),
    .o_q     (w_shreg)
  );

  assign w_shreg_match = (w_shreg == PATTERN);

  always_comb begin
    w_state_next       = r_state;
    w_bit_cnt_next     = r_bit_cnt;
    w_data_out_next    = r_data_out;
    w_data_valid_next  = 1'b0;
    w_match_next       = r_match;
    w_match_count_next = r_match_count;
    w_frame_error_next = 1'b0;
    w_sh_clear         = 1'b0;
    w_sh_load          = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (signal == StartLevel) begin
          w_state_next   = StShift;
          w_bit_cnt_next = '0;
          w_sh_clear     = 1'b1;
        end
      end

      StShift: begin
        w_sh_load = 1'b1;
        if (r_bit_cnt == LastIdx) begin
          w_state_next   = StStop;
          w_bit_cnt_next = '0;
        end else begin
          w_bit_cnt_next = r_bit_cnt + 1'b1;
        end
      end

      StStop: begin
        // A high stop sample is a framing error and is not taken as a new start.
        w_state_next = StIdle;
        if (signal == StopLevel) begin
          w_data_out_next   = w_shreg;
          w_data_valid_next = 1'b1;
          w_match_next      = w_shreg_match;
          if (w_shreg_match && (r_match_count != '1)) begin
            w_match_count_next = r_match_count + CNT_W'(1);
          end
        end else begin
          w_frame_error_next = 1'b1;
        end
      end

      default: begin
        w_state_next   = StIdle;
        w_bit_cnt_next = '0;
      end
    endcase

    w_busy_next = (w_state_next == StShift) || (w_state_next == StStop);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= StIdle;
      r_bit_cnt     <= '0;
      r_data_out    <= '0;
      r_data_valid  <= 1'b0;
      r_match       <= 1'b0;
      r_match_count <= '0;
      r_frame_error <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_bit_cnt     <= w_bit_cnt_next;
      r_data_out    <= w_data_out_next;
      r_data_valid  <= w_data_valid_next;
      r_match       <= w_match_next;
      r_match_count <= w_match_count_next;
      r_frame_error <= w_frame_error_next;
      r_busy        <= w_busy_next;
    end
  end

  assign data_out    = r_data_out;
  assign data_valid  = r_data_valid;
  assign match       = r_match;
  assign match_count = r_match_count;
  assign frame_error = r_frame_error;
  assign busy        = r_busy;

endmodule

// File: tb/tb_pulse_frame_receiver.sv
// Scoreboard bench for pulse_frame_receiver: frame-level reference model feeds
// an expectation queue; a negedge monitor pops on each strobe and compares.
module tb_pulse_frame_receiver;

  localparam int          DW     = 10;
  localparam logic [9:0]  PAT    = 10'h14A;
  localparam int          CW     = 2;
  localparam int          CntMax = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          signal = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          match;
  logic [CW-1:0] match_count;
  logic          frame_error;
  logic          busy;

  pulse_frame_receiver #(
    .DATA_W  (DW),
    .PATTERN (PAT),
    .CNT_W   (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .signal      (signal),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .match       (match),
    .match_count (match_count),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned   cyc;
    bit            bad;
    logic [DW-1:0] data;
    bit            m;
    int            cnt;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;
  int          model_cnt = 0;
  int          hold_data = 0;
  int          hold_m = 0;
  int          hold_cnt = 0;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input bit b);
    @(posedge clock);
    #1 signal = b;
  endtask

  // Frame-level model: the result of a frame is known once its stop bit is chosen.
  task automatic send_frame(input logic [DW-1:0] d, input bit stop_bit);
    exp_t e;
    drive(1'b1);
    for (int i = 0; i < DW; i++) drive(d[i]);
    drive(stop_bit);
    e.cyc  = cyc + 1;
    e.bad  = stop_bit;
    e.data = d;
    e.m    = (d == PAT);
    if (!stop_bit && d == PAT && model_cnt < CntMax) model_cnt++;
    e.cnt  = model_cnt;
    q.push_back(e);
  endtask

  task automatic do_reset();
    drive(1'b0);
    drive(1'b0);
    #1 reset = 1'b1;
    model_cnt = 0;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        hold_data = 0;
        hold_m    = 0;
        hold_cnt  = 0;
      end else begin
        if (data_valid && frame_error) check("strobes_exclusive", 1, 0);
        if (data_valid || frame_error) begin
          if (q.size() == 0) begin
            check("unexpected_strobe", int'({data_valid, frame_error}), 0);
          end else begin
            e = q.pop_front();
            check("strobe_cycle", int'(cyc), int'(e.cyc));
            check("strobe_kind_fe", int'(frame_error), int'(e.bad));
            if (!e.bad) begin
              hold_data = int'(e.data);
              hold_m    = int'(e.m);
              hold_cnt  = e.cnt;
            end
          end
        end else if (q.size() > 0 && cyc >= q[0].cyc) begin
          check("missing_strobe", 0, 1);
          void'(q.pop_front());
        end
        check("data_out", int'(data_out), hold_data);
        check("match", int'(match), hold_m);
        check("match_count", int'(match_count), hold_cnt);
      end
    end
  end

  initial begin
    logic [DW-1:0] pv;
    logic [DW-1:0] d;
    bit            bad;
    int            gap;
    pv = PAT;

    // Reset values, visible without any clock edge.
    #3;
    check("rst_data_out", int'(data_out), 0);
    check("rst_data_valid", int'(data_valid), 0);
    check("rst_match", int'(match), 0);
    check("rst_match_count", int'(match_count), 0);
    check("rst_frame_error", int'(frame_error), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge clock);
    #1 reset = 1'b0;
    drive(1'b0);

    // Matching frame, then non-matching all-ones frame.
    send_frame(PAT, 1'b0);
    send_frame(10'h3FF, 1'b0);
    drive(1'b0);

    // Bad stop bit: error strobe, outputs hold, high stop not reused as start.
    send_frame(PAT, 1'b1);
    drive(1'b0);
    check("badstop_busy", int'(busy), 0);
    check("badstop_fe", int'(frame_error), 1);
    drive(1'b0);
    check("after_bad_busy", int'(busy), 0);
    check("after_bad_fe", int'(frame_error), 0);
    check("after_bad_dv", int'(data_valid), 0);
    repeat (3) drive(1'b0);

    // Reset mid-frame after five data bits: async clear, then a clean frame.
    drive(1'b1);
    for (int i = 0; i < 5; i++) drive(pv[i]);
    check("midframe_busy_before", int'(busy), 1);
    #2 reset = 1'b1;
    signal = 1'b0;
    model_cnt = 0;
    #1;
    check("midrst_data_out", int'(data_out), 0);
    check("midrst_match", int'(match), 0);
    check("midrst_match_count", int'(match_count), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_dv", int'(data_valid), 0);
    check("midrst_fe", int'(frame_error), 0);
    @(posedge clock);
    #1 reset = 1'b0;
    send_frame(PAT, 1'b0);

    // Back-to-back matching frames: count 1,2,3,3,3 with CNT_W=2.
    do_reset();
    repeat (5) send_frame(PAT, 1'b0);

    // Idle line after reset.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      drive(1'b0);
      check("idle_busy", int'(busy), 0);
      check("idle_dv", int'(data_valid), 0);
      check("idle_fe", int'(frame_error), 0);
    end

    // Randomized frames with random gaps, including zero-gap back-to-back.
    for (int k = 0; k < 40; k++) begin
      d   = ($urandom_range(3) == 0) ? PAT : DW'($urandom);
      bad = ($urandom_range(4) == 0);
      gap = $urandom_range(2);
      if (bad && gap == 0) gap = 1;
      send_frame(d, bad);
      repeat (gap) drive(1'b0);
    end

    repeat (5) drive(1'b0);
    check("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
